// File: rtl/bitserial_alu_seq_if.sv
// bitserial_alu_seq_if: groups the requester-side and ALU-side signals of the
// bit-serial ALU sequencer. The slave modport is the sequencer's view. The master
// modport is the view of the environment around it: the requester plus the serial ALU.
interface bitserial_alu_seq_if #(
    parameter int unsigned W = 8
);
    // Requester side
    logic         start;
    logic [3:0]   op_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    // Serial ALU side
    logic [3:0]   alu_op;
    logic         alu_a;
    logic         alu_b;
    logic         alu_rstn;
    logic         alu_out;

    modport master (
        output start, op_in, a_in, b_in, alu_out,
        input  busy, done, err, result, alu_op, alu_a, alu_b, alu_rstn
    );

    modport slave (
        input  start, op_in, a_in, b_in, alu_out,
        output busy, done, err, result, alu_op, alu_a, alu_b, alu_rstn
    );
endinterface

// File: rtl/bitserial_alu_seq.sv
// bitserial_alu_seq: latches a parallel opcode and two W-bit operands. It clears the
// serial ALU for one cycle and then streams the operand bits LSB-first for W cycles.
// The ALU's registered output bits are collected into a W-bit result, and completion
// is marked with a one-cycle done pulse.
// Optional feature: define BSEQ_OPCHECK_EN to reject illegal opcodes in IDLE. A
// rejected request pulses err and done together and never leaves IDLE.
module bitserial_alu_seq #(
    parameter int unsigned W = 8
) (
    input logic               clk,
    input logic               rstn,
    bitserial_alu_seq_if.slave bus
);
    localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClr   = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    cap_q, cap_d;
    logic [W-1:0]    result_q, result_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            op_legal;

`ifdef BSEQ_OPCHECK_EN
    // Decode of the opcodes the ALU implements
    always_comb begin
        case (bus.op_in)
            4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1100: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    end
`else
    // Without the check every opcode runs the full sequence
    assign op_legal = 1'b1;
`endif

    // Next-state logic for the sequence IDLE -> CLR -> RUN (W cycles) -> DRAIN
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cap_d    = cap_q;
        result_d = result_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (op_legal) begin
                        op_d    = bus.op_in;
                        a_d     = bus.a_in;
                        b_d     = bus.b_in;
                        state_d = StClr;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            StClr: begin
                idx_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                // alu_out lags the presented bits by one cycle, so bit idx-1 arrives now
                if (idx_q != '0) begin
                    cap_d = {bus.alu_out, cap_q[W-1:1]};
                end
                if (idx_q == IdxW'(W - 1)) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: begin
                // DRAIN: the last bit (W-1) is on alu_out this cycle
                cap_d    = {bus.alu_out, cap_q[W-1:1]};
                result_d = {bus.alu_out, cap_q[W-1:1]};
                done_d   = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cap_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cap_q    <= cap_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Outputs are gated by rstn, so a reset forces them to their idle values in the
    // same cycle. alu_rstn follows rstn directly, so a block reset also clears the ALU.
    assign bus.busy     = rstn & (state_q != StIdle);
    assign bus.done     = rstn & done_q;
    assign bus.err      = rstn & err_q;
    assign bus.result   = rstn ? result_q : '0;
    assign bus.alu_op   = rstn ? op_q : 4'b0000;
    assign bus.alu_a    = rstn & (state_q == StRun) & a_q[idx_q];
    assign bus.alu_b    = rstn & (state_q == StRun) & b_q[idx_q];
    assign bus.alu_rstn = rstn & (state_q != StClr);
endmodule

// File: tb/tb_bitserial_alu_seq.sv
// tb_bitserial_alu_seq: drives requests into bitserial_alu_seq and models the 1-bit
// serial ALU behaviourally. Expected results come from whole-word arithmetic and are
// pushed to a queue when a request is issued, then popped when done is due.
module tb_bitserial_alu_seq;
    localparam int unsigned W   = 8;
    localparam int unsigned Lat = W + 3;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;
    logic         alu_c;
    logic         alu_o;

    bitserial_alu_seq_if #(.W(W)) bus ();

    bitserial_alu_seq #(.W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serial ALU with registered output and a carry/borrow flop
    always @(posedge clk) begin
        if (!bus.alu_rstn) begin
            alu_c <= 1'b0;
            alu_o <= 1'b0;
        end else begin
            case (bus.alu_op)
                4'b0000: begin
                    alu_o <= bus.alu_a ^ alu_c;
                    alu_c <= bus.alu_a | alu_c;
                end
                4'b0001: begin
                    alu_o <= bus.alu_a ^ bus.alu_b ^ alu_c;
                    alu_c <= (bus.alu_a & bus.alu_b) | (alu_c & (bus.alu_a ^ bus.alu_b));
                end
                4'b1000: alu_o <= ~bus.alu_a;
                4'b1001: alu_o <= bus.alu_a | bus.alu_b;
                4'b1010: alu_o <= bus.alu_a & bus.alu_b;
                4'b1100: alu_o <= bus.alu_a ^ bus.alu_b;
                default: ;
            endcase
        end
    end
    assign bus.alu_out = alu_o;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            4'b0000: return -a;
            4'b0001: return a + b;
            4'b1000: return ~a;
            4'b1001: return a | b;
            4'b1010: return a & b;
            4'b1100: return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op_in = 4'b0000;
        bus.a_in  = '0;
        bus.b_in  = '0;
        rstn      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/err=%b required 000",
                     {bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h required 00", bus.result);
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rstn} !== 7'b0) begin
            errors++;
            $display("FAIL reset_alu_if: op/a/b/rstn=%b required 0000000",
                     {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rstn});
        end
        rstn     = 1'b1;
        last_res = '0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.alu_rstn} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release: busy/alu_rstn=%b required 01",
                     {bus.busy, bus.alu_rstn});
        end
    endtask

    // Issues one request at the current mid-cycle point (T0). It checks the control
    // timing every cycle through the done cycle T(W+3) and returns in that cycle.
    task automatic test_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string name);
        logic [5:0]   obs;
        logic [5:0]   want;
        logic         sa;
        logic         sb;
        logic [W-1:0] exp;
        bus.start = 1'b1;
        bus.op_in = op;
        bus.a_in  = a;
        bus.b_in  = b;
        exp_q.push_back(ref_alu(op, a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = W'($urandom);
        bus.b_in  = W'($urandom);
        for (int k = 1; k <= int'(Lat); k++) begin
            @(negedge clk);
            sa   = (k >= 2 && k <= int'(W) + 1) ? a[k-2] : 1'b0;
            sb   = (k >= 2 && k <= int'(W) + 1) ? b[k-2] : 1'b0;
            want = {(k <= int'(W) + 2), (k == int'(Lat)), 1'b0, (k != 1), sa, sb};
            obs  = {bus.busy, bus.done, bus.err, bus.alu_rstn, bus.alu_a, bus.alu_b};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL %s T%0d busy/done/err/alu_rstn/alu_a/alu_b: got %b required %b",
                         name, k, obs, want);
            end
            if (k == int'(Lat)) begin
                exp = exp_q.pop_front();
                checks++;
                if (bus.result !== exp) begin
                    errors++;
                    $display("FAIL %s result: got %h required %h", name, bus.result, exp);
                end
                last_res = exp;
            end
        end
    endtask

    task automatic test_add();
        test_op(4'b0001, 8'h5A, 8'h3C, "add_5a_3c");
        test_op(4'b0001, 8'hFF, 8'h01, "add_carry_drop");
    endtask

    // Called directly in the previous done cycle, so the start is back-to-back
    task automatic test_back_to_back();
        test_op(4'b1010, 8'hF0, 8'h3C, "band_b2b");
    endtask

    task automatic test_logic_ops();
        test_op(4'b1100, 8'hA5, 8'hFF, "bxor");
        test_op(4'b1001, 8'h0C, 8'h30, "bor");
        test_op(4'b1000, 8'hA5, 8'h00, "bneg");
        test_op(4'b0000, 8'h01, 8'h00, "neg");
    endtask

    task automatic test_busy_ignore();
        int           dones;
        logic [W-1:0] exp;
        bus.start = 1'b1;
        bus.op_in = 4'b1100;
        bus.a_in  = 8'hA5;
        bus.b_in  = 8'hFF;
        exp_q.push_back(ref_alu(4'b1100, 8'hA5, 8'hFF));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones     = 0;
        for (int k = 1; k <= int'(Lat) + 4; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (k == int'(Lat)) begin
                exp = exp_q.pop_front();
                checks++;
                if (bus.result !== exp) begin
                    errors++;
                    $display("FAIL busy_ignore result: got %h required %h", bus.result, exp);
                end
                last_res = exp;
            end
            if (k > int'(Lat)) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ignore queued T%0d: busy=%b required 0", k, bus.busy);
                end
            end
            // Second request while busy; it must be dropped
            if (k == 3) begin
                bus.start = 1'b1;
                bus.op_in = 4'b0001;
                bus.a_in  = 8'h01;
                bus.b_in  = 8'h01;
            end
            if (k == 6) bus.start = 1'b0;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_ignore done_count: got %0d required 1", dones);
        end
        checks++;
        if (bus.result !== last_res) begin
            errors++;
            $display("FAIL busy_ignore held: got %h required %h", bus.result, last_res);
        end
    endtask

    task automatic test_illegal();
`ifdef BSEQ_OPCHECK_EN
        bus.start = 1'b1;
        bus.op_in = 4'b0011;
        bus.a_in  = 8'h11;
        bus.b_in  = 8'h22;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.alu_rstn} !== 4'b0111) begin
            errors++;
            $display("FAIL illegal T1 busy/done/err/alu_rstn: got %b required 0111",
                     {bus.busy, bus.done, bus.err, bus.alu_rstn});
        end
        checks++;
        if (bus.result !== last_res) begin
            errors++;
            $display("FAIL illegal result: got %h required %h", bus.result, last_res);
        end
        for (int k = 2; k <= int'(Lat) + 1; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.err, bus.alu_rstn, bus.alu_a, bus.alu_b} !== 6'b000100)
            begin
                errors++;
                $display("FAIL illegal T%0d busy/done/err/alu_rstn/alu_a/alu_b: got %b required 000100",
                         k, {bus.busy, bus.done, bus.err, bus.alu_rstn, bus.alu_a, bus.alu_b});
            end
        end
`else
        test_op(4'b0011, 8'h11, 8'h22, "unlisted_op");
`endif
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        bus.op_in = 4'b0001;
        bus.a_in  = 8'h5A;
        bus.b_in  = 8'h3C;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.alu_rstn} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid T5 busy/done/alu_rstn: got %b required 000",
                     {bus.busy, bus.done, bus.alu_rstn});
        end
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("FAIL reset_mid T5 result: got %h required 00", bus.result);
        end
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        last_res = '0;
        for (int k = 1; k <= int'(Lat) + 2; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done} !== 2'b00 || bus.result !== '0) begin
                errors++;
                $display("FAIL reset_mid after T%0d busy/done=%b result=%h required 00 and 00",
                         k, {bus.busy, bus.done}, bus.result);
            end
        end
        test_op(4'b0001, 8'h03, 8'h04, "add_after_reset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_logic_ops();
        test_busy_ignore();
        test_illegal();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
